// File: rtl/mul_div_seq_if.sv
// Start/done handshake and operand bus between EX and the iterative multiply/divide unit.
interface mul_div_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [3:0]      op;
  logic            is_word_op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, is_word_op, operand_a, operand_b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, is_word_op, operand_a, operand_b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/mul_div_seq.sv
// Iterative M-extension unit: shift-add multiply and restoring divide, one bit per cycle,
// with divide-by-zero and signed overflow resolved at start.
module mul_div_seq #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          reset_n,
  mul_div_seq_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     r_last;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_div;
  logic [2:0]        r_f3;
  logic              r_word;
  logic              r_neg_q;
  logic              r_neg_r;

  function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
    logic [XLEN-1:0] r;
    r       = {XLEN{sgn & v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] fix_w(input logic [XLEN-1:0] v, input logic word);
    logic [XLEN-1:0] r;
    if (word) begin
      r = ext32(v[31:0], 1'b1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic [2:0]      w_f3;
  logic            w_unused_op;
  logic            w_word, w_sa, w_sb, w_neg_a, w_neg_b;
  logic            w_div_zero, w_ovf, w_special;
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_mag_a, w_mag_b, w_min, w_spec_raw, w_spec_res;

  assign w_f3        = bus.op[2:0];
  assign w_unused_op = bus.op[3];
  assign w_word      = (XLEN == 64) && bus.is_word_op;
  assign w_sa        = (w_f3 == 3'b001) | (w_f3 == 3'b010) | (w_f3 == 3'b100) | (w_f3 == 3'b110);
  assign w_sb        = (w_f3 == 3'b001) | (w_f3 == 3'b100) | (w_f3 == 3'b110);

  // Operand extension to the op width
  always_comb begin
    w_a_ext = bus.operand_a;
    w_b_ext = bus.operand_b;
    if (w_word) begin
      w_a_ext = ext32(bus.operand_a[31:0], w_sa);
      w_b_ext = ext32(bus.operand_b[31:0], w_sb);
    end else begin
      w_a_ext = bus.operand_a;
      w_b_ext = bus.operand_b;
    end
  end

  assign w_neg_a    = w_sa & w_a_ext[XLEN-1];
  assign w_neg_b    = w_sb & w_b_ext[XLEN-1];
  assign w_mag_a    = w_neg_a ? -w_a_ext : w_a_ext;
  assign w_mag_b    = w_neg_b ? -w_b_ext : w_b_ext;
  assign w_min      = w_word ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
  assign w_div_zero = (w_b_ext == {XLEN{1'b0}});
  assign w_ovf      = w_sa & (w_a_ext == w_min) & (w_b_ext == {XLEN{1'b1}});
  assign w_special  = w_f3[2] & (w_div_zero | w_ovf);

  // Early result for divide-by-zero and signed overflow
  always_comb begin
    w_spec_raw = {XLEN{1'b0}};
    if (w_div_zero) begin
      w_spec_raw = w_f3[1] ? w_a_ext : {XLEN{1'b1}};
    end else begin
      w_spec_raw = w_f3[1] ? {XLEN{1'b0}} : w_a_ext;
    end
    w_spec_res = fix_w(w_spec_raw, w_word);
  end

  logic [2*XLEN-1:0] w_acc_nxt, w_prod;
  logic [XLEN-1:0]   w_mul_res;
  logic              w_top, w_qbit;
  logic [XLEN:0]     w_shift, w_diff;
  logic [XLEN-1:0]   w_rem_nxt, w_quo_nxt, w_q_fin, w_r_fin, w_div_res;

  // Multiplicand shifts left while multiplier shifts right, so word ops finish after 32 steps
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : {(2*XLEN){1'b0}});
  assign w_prod    = r_neg_q ? -w_acc_nxt : w_acc_nxt;
  assign w_mul_res = fix_w((r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN], r_word);

  assign w_top     = r_word ? r_quo[31] : r_quo[XLEN-1];
  assign w_shift   = {r_rem, w_top};
  assign w_diff    = w_shift - {1'b0, r_div};
  assign w_qbit    = ~w_diff[XLEN];
  assign w_rem_nxt = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_qbit};
  assign w_q_fin   = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_r_fin   = r_neg_r ? -w_rem_nxt : w_rem_nxt;
  assign w_div_res = fix_w(r_f3[1] ? w_r_fin : w_q_fin, r_word);

  // Sequencer: operand latch, per-cycle step, registered result and handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CW{1'b0}};
      r_last   <= {CW{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= {XLEN{1'b0}};
      r_acc    <= {(2*XLEN){1'b0}};
      r_mcand  <= {(2*XLEN){1'b0}};
      r_mplier <= {XLEN{1'b0}};
      r_quo    <= {XLEN{1'b0}};
      r_rem    <= {XLEN{1'b0}};
      r_div    <= {XLEN{1'b0}};
      r_f3     <= 3'b000;
      r_word   <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (bus.flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_cnt    <= {CW{1'b0}};
            r_last   <= w_word ? CW'(31) : CW'(XLEN - 1);
            r_f3     <= w_f3;
            r_word   <= w_word;
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= w_neg_a;
            r_acc    <= {(2*XLEN){1'b0}};
            r_mcand  <= {{XLEN{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_quo    <= w_mag_a;
            r_rem    <= {XLEN{1'b0}};
            r_div    <= w_mag_b;
            if (!w_f3[2]) begin
              r_state <= S_MUL;
              r_busy  <= 1'b1;
            end else if (w_special) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_spec_res;
            end else begin
              r_state <= S_DIV;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= {r_mcand[2*XLEN-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
          if (r_cnt == r_last) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_mul_res;
          end else begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_DIV: begin
          r_quo <= w_quo_nxt;
          r_rem <= w_rem_nxt;
          if (r_cnt == r_last) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_div_res;
          end else begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
endmodule

// File: tb/tb_mul_div_seq.sv
// Scoreboard bench for mul_div_seq: XLEN=32 and XLEN=64 instances, directed vectors.
module tb_mul_div_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mul_div_seq_if #(.XLEN(32)) if32 ();
  mul_div_seq_if #(.XLEN(64)) if64 ();

  mul_div_seq #(.XLEN(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(if32));
  mul_div_seq #(.XLEN(64)) dut64 (.clk(clk), .reset_n(reset_n), .bus(if64));

  typedef struct {
    logic [63:0] res;
    int          cyc;
    int          nbusy;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int busy32 = 0;
  int busy64 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor for the 32-bit instance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) busy32 = 0;
      else begin
        if (if32.busy) busy32++;
        if (if32.done) begin
          if (q32.size() == 0) begin
            n_total++;
            $display("FAIL done32_unexpected: done high with result 0x%0h, none outstanding", if32.result);
          end else begin
            e = q32.pop_front();
            check("result32", {32'd0, if32.result}, e.res);
            check("latency32", 64'(cyc), 64'(e.cyc));
            check("busy_cycles32", 64'(busy32), 64'(e.nbusy));
          end
          busy32 = 0;
        end
        if (if32.flush) busy32 = 0;
      end
    end
  end

  // Monitor for the 64-bit instance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) busy64 = 0;
      else begin
        if (if64.busy) busy64++;
        if (if64.done) begin
          if (q64.size() == 0) begin
            n_total++;
            $display("FAIL done64_unexpected: done high with result 0x%0h, none outstanding", if64.result);
          end else begin
            e = q64.pop_front();
            check("result64", if64.result, e.res);
            check("latency64", 64'(cyc), 64'(e.cyc));
            check("busy_cycles64", 64'(busy64), 64'(e.nbusy));
          end
          busy64 = 0;
        end
        if (if64.flush) busy64 = 0;
      end
    end
  end

  // Drive one start pulse in the current cycle; n = iterations (0 for special cases)
  task automatic issue_now(input bit sel, input logic [3:0] op, input logic word,
                           input logic [63:0] a, input logic [63:0] b,
                           input bit push, input logic [63:0] res, input int n);
    exp_t e;
    e.res   = res;
    e.cyc   = cyc + n + 1;
    e.nbusy = n;
    if (sel) begin
      if64.start = 1'b1; if64.op = op; if64.is_word_op = word;
      if64.operand_a = a; if64.operand_b = b;
      if (push) q64.push_back(e);
    end else begin
      if32.start = 1'b1; if32.op = op; if32.is_word_op = word;
      if32.operand_a = a[31:0]; if32.operand_b = b[31:0];
      if (push) q32.push_back(e);
    end
    @(posedge clk); #1;
    if32.start = 1'b0;
    if64.start = 1'b0;
  endtask

  task automatic issue(input bit sel, input logic [3:0] op, input logic word,
                       input logic [63:0] a, input logic [63:0] b,
                       input bit push, input logic [63:0] res, input int n);
    @(posedge clk); #1;
    issue_now(sel, op, word, a, b, push, res, n);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((q32.size() + q64.size()) != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    check(name, 64'(q32.size() + q64.size()), 64'd0);
    q32.delete();
    q64.delete();
  endtask

  initial begin
    int t;
    if32.start = 1'b0; if32.op = 4'd0; if32.is_word_op = 1'b0;
    if32.operand_a = 32'd0; if32.operand_b = 32'd0; if32.flush = 1'b0;
    if64.start = 1'b0; if64.op = 4'd0; if64.is_word_op = 1'b0;
    if64.operand_a = 64'd0; if64.operand_b = 64'd0; if64.flush = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy32", 64'(if32.busy), 64'd0);
    check("reset_done32", 64'(if32.done), 64'd0);
    check("reset_result32", {32'd0, if32.result}, 64'd0);
    check("reset_busy64", 64'(if64.busy), 64'd0);
    check("reset_done64", 64'(if64.done), 64'd0);
    check("reset_result64", if64.result, 64'd0);
    reset_n = 1'b1;

    // Multiply family
    issue(0, 4'd0, 1'b0, 64'd7, 64'hFFFF_FFFD, 1, 64'hFFFF_FFEB, 32);       drain("drain_mul");
    issue(0, 4'd3, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1, 64'hFFFF_FFFE, 32); drain("drain_mulhu");
    issue(0, 4'd1, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1, 64'h0, 32);         drain("drain_mulh");
    issue(0, 4'd2, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1, 64'hFFFF_FFFF, 32); drain("drain_mulhsu");

    // Divide family (op bit 3 set once to show it is ignored)
    issue(0, 4'd4, 1'b0, 64'hFFFF_FFF9, 64'd2, 1, 64'hFFFF_FFFD, 32); drain("drain_div");
    issue(0, 4'd6, 1'b0, 64'hFFFF_FFF9, 64'd2, 1, 64'hFFFF_FFFF, 32); drain("drain_rem");
    issue(0, 4'hD, 1'b0, 64'd100, 64'd7, 1, 64'd14, 32);              drain("drain_divu");
    issue(0, 4'd7, 1'b0, 64'd100, 64'd7, 1, 64'd2, 32);               drain("drain_remu");

    // Special cases: done one cycle after start, busy never high
    issue(0, 4'd4, 1'b0, 64'd5, 64'd0, 1, 64'hFFFF_FFFF, 0);                 drain("drain_div0");
    issue(0, 4'd6, 1'b0, 64'd5, 64'd0, 1, 64'd5, 0);                         drain("drain_rem0");
    issue(0, 4'd4, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 1, 64'h8000_0000, 0); drain("drain_divovf");
    issue(0, 4'd6, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 1, 64'h0, 0);         drain("drain_removf");

    // Start while busy is ignored
    issue(0, 4'd0, 1'b0, 64'h1234, 64'h10, 1, 64'h12340, 32);
    repeat (4) @(posedge clk);
    #1;
    issue_now(0, 4'd4, 1'b0, 64'd9, 64'd3, 0, 64'd0, 32);
    repeat (10) @(posedge clk);
    #1;
    issue_now(0, 4'd5, 1'b0, 64'd9, 64'd0, 0, 64'd0, 0);
    drain("drain_start_busy");

    // Flush ten cycles into a divide
    issue(0, 4'd5, 1'b0, 64'd1000, 64'd3, 0, 64'd0, 32);
    repeat (9) @(posedge clk);
    #1;
    if32.flush = 1'b1;
    @(posedge clk); #1;
    if32.flush = 1'b0;
    check("flush_busy", 64'(if32.busy), 64'd0);
    check("flush_done", 64'(if32.done), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_result_kept", {32'd0, if32.result}, 64'h12340);

    // Back-to-back: second start in the done cycle
    issue(0, 4'd0, 1'b0, 64'd3, 64'd4, 1, 64'd12, 32);
    t = 0;
    while (if32.done !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("b2b_first_done_seen", 64'(if32.done), 64'd1);
    issue_now(0, 4'd5, 1'b0, 64'd1000, 64'd10, 1, 64'd100, 32);
    drain("drain_b2b");

    // Asynchronous reset mid-multiply
    issue(0, 4'd0, 1'b0, 64'hFFFF, 64'hFFFF, 0, 64'd0, 32);
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(if32.busy), 64'd0);
    check("async_rst_done", 64'(if32.done), 64'd0);
    check("async_rst_result", {32'd0, if32.result}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // XLEN=64 instance: word forms and full width
    issue(1, 4'd4, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFD, 32); drain("drain_divw");
    issue(1, 4'd0, 1'b1, 64'h4000_0000, 64'd2, 1, 64'hFFFF_FFFF_8000_0000, 32);           drain("drain_mulw");
    issue(1, 4'd0, 1'b0, 64'h0000_0001_0000_0003, 64'd5, 1, 64'h0000_0005_0000_000F, 64); drain("drain_mul64");
    issue(1, 4'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1,
          64'hFFFF_FFFF_FFFF_FFFE, 64);                                                    drain("drain_mulhu64");
    issue(1, 4'd7, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'd7, 1, 64'd2, 32);                   drain("drain_remuw");
    issue(1, 4'd7, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0005_0000_0000, 1,
          64'hFFFF_FFFF_8000_0000, 0);                                                     drain("drain_remuw0");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
